// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst master.
package ram_burst_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain
    } state_e;

    // Read-return buffer depth and the matching occupancy counter width
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    // Width of the optional saturating stall counter
    localparam int unsigned STALL_WIDTH = 16;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry FIFO holding RAM read returns until the consumer takes them.
// Push and pop may happen in the same cycle.
module ram_rd_skid
    import ram_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [SKID_CNT_W-1:0] o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned PTR_W = $clog2(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [SKID_CNT_W-1:0] r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == SKID_CNT_W'(SKID_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full buffer can still take a push when the head leaves this cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Data storage needs no reset; occupancy alone decides validity
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + SKID_CNT_W'(w_do_push) - SKID_CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM. Write bursts stream WrData straight
// into RAM writes; read bursts issue addresses and return data through a 2-entry skid
// buffer under RdValid/RdReady flow control.
// Optional: define RAM_BURST_STATS_EN to add the saturating StallCount output.
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   CmdValid,
    output logic                   CmdReady,
    input  logic                   CmdWrite,
    input  logic [ADDR_WIDTH-1:0]  CmdAddr,
    input  logic [LEN_WIDTH-1:0]   CmdLen,
    input  logic [DATA_WIDTH-1:0]  WrData,
    input  logic                   WrValid,
    output logic                   WrReady,
    output logic [DATA_WIDTH-1:0]  RdData,
    output logic                   RdValid,
    input  logic                   RdReady,
    output logic                   Done,
    output logic                   Busy,
    output logic [ADDR_WIDTH-1:0]  MemAddr,
    output logic                   MemWrite,
    output logic [DATA_WIDTH-1:0]  MemInput,
    input  logic [DATA_WIDTH-1:0]  MemOutput
`ifdef RAM_BURST_STATS_EN
    ,
    output logic [STALL_WIDTH-1:0] StallCount
`endif
);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_inflight;
    logic                  r_done;

    logic [SKID_CNT_W-1:0] w_skid_count;
    logic                  w_skid_full;
    logic                  w_skid_empty;
    logic [DATA_WIDTH-1:0] w_skid_head;
    logic                  w_pop;
    logic [2:0]            w_occupancy;
    logic                  w_issue;
    logic                  w_last_word;
    logic                  w_drain_done;

    assign CmdReady = (r_state == StIdle);
    assign Busy     = (r_state != StIdle);
    assign WrReady  = (r_state == StWrite);
    // Gated with Reset so the edge that aborts a burst never writes the RAM
    assign MemWrite = WrReady && WrValid && !Reset;
    assign MemInput = WrReady ? WrData : '0;
    assign MemAddr  = r_addr;
    assign Done     = r_done;
    assign RdValid  = !w_skid_empty;
    assign RdData   = w_skid_head;

    assign w_pop       = RdValid && RdReady;
    assign w_last_word = (r_remaining == LEN_WIDTH'(1));
    // Buffered + returning - leaving: issue only while a slot is guaranteed
    assign w_occupancy = 3'(w_skid_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue     = (r_state == StRead) && (w_occupancy < 3'd2);
    // Leave DRAIN on the edge that takes the final word
    assign w_drain_done = !r_inflight &&
                          (w_skid_empty || ((w_skid_count == SKID_CNT_W'(1)) && w_pop));

    ram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_skid (
        .i_clk       (Clk),
        .i_reset     (Reset),
        .i_push      (r_inflight),
        .i_push_data (MemOutput),
        .i_pop       (w_pop),
        .o_head      (w_skid_head),
        .o_count     (w_skid_count),
        .o_full      (w_skid_full),
        .o_empty     (w_skid_empty)
    );

    // Burst sequencing: command latch, address/length stepping, completion pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            case (r_state)
                StIdle: begin
                    if (CmdValid) begin
                        r_addr      <= CmdAddr;
                        r_remaining <= CmdLen;
                        if (CmdLen == '0) begin
                            r_done <= 1'b1;
                        end else if (CmdWrite) begin
                            r_state <= StWrite;
                        end else begin
                            r_state <= StRead;
                        end
                    end
                end
                StWrite: begin
                    if (WrValid) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (w_last_word) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (w_last_word) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_drain_done) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // The issue rule must never return a word into a buffer that cannot take it
    assert property (@(posedge Clk) disable iff (Reset)
        !(r_inflight && w_skid_full && !w_pop));

`ifdef RAM_BURST_STATS_EN
    logic [STALL_WIDTH-1:0] r_stall_count;
    logic                   w_stall;

    assign w_stall = (WrReady && !WrValid) ||
                     (((r_state == StRead) || (r_state == StDrain)) && RdValid && !RdReady);
    assign StallCount = r_stall_count;

    // Saturating stall counter, restarted by every accepted command
    always_ff @(posedge Clk) begin
        if (Reset || (CmdValid && CmdReady)) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + STALL_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomized self-checking bench for ram_burst_master with a behavioural RAM and an
// array-based reference memory of what the RAM should hold.
// Honours RAM_BURST_STATS_EN when the design is built with it.
module tb_ram_burst_master;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       CmdValid, CmdReady, CmdWrite;
    logic [7:0] CmdAddr, CmdLen;
    logic [7:0] WrData;
    logic       WrValid, WrReady;
    logic [7:0] RdData;
    logic       RdValid, RdReady;
    logic       Done, Busy;
    logic [7:0] MemAddr;
    logic       MemWrite;
    logic [7:0] MemInput, MemOutput;
`ifdef RAM_BURST_STATS_EN
    logic [15:0] StallCount;
`endif

    ram_burst_master #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .LEN_WIDTH  (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdWrite   (CmdWrite),
        .CmdAddr    (CmdAddr),
        .CmdLen     (CmdLen),
        .WrData     (WrData),
        .WrValid    (WrValid),
        .WrReady    (WrReady),
        .RdData     (RdData),
        .RdValid    (RdValid),
        .RdReady    (RdReady),
        .Done       (Done),
        .Busy       (Busy),
        .MemAddr    (MemAddr),
        .MemWrite   (MemWrite),
        .MemInput   (MemInput),
        .MemOutput  (MemOutput)
`ifdef RAM_BURST_STATS_EN
        ,
        .StallCount (StallCount)
`endif
    );

    always #5 Clk = ~Clk;

    // Behavioural single-port RAM: output valid one cycle after the address
    logic [7:0] ram [256];
    always @(posedge Clk) begin
        if (MemWrite) ram[MemAddr] <= MemInput;
        MemOutput <= ram[MemAddr];
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event log gathered mid-cycle
    int         wr_cyc[$];
    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         rd_cyc[$];
    logic [7:0] rd_data[$];
    int         done_cyc[$];
    int         stall_obs = 0;
    int         rdv_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge Clk) begin
        if (MemWrite) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(MemAddr);
            wr_data.push_back(MemInput);
        end
        if (RdValid && RdReady) begin
            rd_cyc.push_back(cyc);
            rd_data.push_back(RdData);
        end
        if (Done) done_cyc.push_back(cyc);
        if (RdValid) rdv_cnt <= rdv_cnt + 1;
        if (RdValid && !RdReady) stall_obs <= stall_obs + 1;
        if (prev_stall && !Reset) begin
            check_eq("rd_hold_valid", RdValid, 1);
            check_eq("rd_hold_data", RdData, prev_data);
        end
        prev_stall <= RdValid && !RdReady && !Reset;
        prev_data  <= RdData;
    end

    // Reference model: what the RAM must contain, and write data per burst word
    logic [7:0] ref_mem [256];
    logic [7:0] wdata [256];

    int acc_cyc;
    int wr_base, rd_base, done_base, stall_base, rdv_base;

    task automatic send_cmd(input logic wr, input logic [7:0] a, input int len);
        bit got = 0;
        CmdValid = 1'b1;
        CmdWrite = wr;
        CmdAddr  = a;
        CmdLen   = 8'(len);
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge Clk);
            if (CmdReady) begin
                got = 1;
                acc_cyc = cyc;
            end
            @(posedge Clk);
            #1;
        end
        CmdValid = 1'b0;
        if (!got) check_eq("cmd_accept_timeout", 0, 1);
        wr_base    = wr_cyc.size();
        rd_base    = rd_cyc.size();
        done_base  = done_cyc.size();
        stall_base = stall_obs;
        rdv_base   = rdv_cnt;
    endtask

    // Exactly one Done, in the cycle after the burst's final transfer
    task automatic verify_done(input int last_cyc);
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (done_cyc.size() > done_base) break;
        end
        repeat (3) @(negedge Clk);
        check_eq("done_count", done_cyc.size() - done_base, 1);
        if (done_cyc.size() > done_base) check_eq("done_cycle", done_cyc[done_base], last_cyc + 1);
        @(posedge Clk);
        #1;
    endtask

    task automatic write_burst(input logic [7:0] a, input int len, input bit gaps,
                               input bit wait_done);
        int   i = 0;
        int   stalls = 0;
        logic hs;
        logic [7:0] ad;
        send_cmd(1'b1, a, len);
        for (int g = 0; g < 1000 && i < len; g++) begin
            WrData  = wdata[i];
            WrValid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge Clk);
            hs = WrValid && WrReady;
            if (!WrValid) stalls++;
            @(posedge Clk);
            #1;
            if (hs) begin
                ad = a + 8'(i);
                ref_mem[ad] = wdata[i];
                i++;
            end
        end
        WrValid = 1'b0;
        check_eq("wr_count", wr_cyc.size() - wr_base, len);
        for (int j = 0; j < len && wr_base + j < wr_cyc.size(); j++) begin
            ad = a + 8'(j);
            check_eq("wr_addr", wr_addr[wr_base + j], ad);
            check_eq("wr_data", wr_data[wr_base + j], wdata[j]);
            if (!gaps) check_eq("wr_cycle", wr_cyc[wr_base + j], acc_cyc + 1 + j);
        end
        if (wait_done) begin
            verify_done((len == 0 || wr_cyc.size() == wr_base) ? acc_cyc : wr_cyc[$]);
`ifdef RAM_BURST_STATS_EN
            check_eq("wr_stall_count", StallCount, stalls);
`endif
        end
    endtask

    // mode 0: RdReady held high, 1: pattern 1,0,0 repeating, 2: random
    task automatic read_burst(input logic [7:0] a, input int len, input int mode);
        logic [7:0] ad;
        int k = 0;
        send_cmd(1'b0, a, len);
        while (rd_cyc.size() - rd_base < len && k < 2000) begin
            RdReady = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 3) == 0) : 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
            k++;
        end
        RdReady = 1'b0;
        check_eq("rd_count", rd_cyc.size() - rd_base, len);
        for (int j = 0; j < len && rd_base + j < rd_cyc.size(); j++) begin
            ad = a + 8'(j);
            check_eq("rd_data", rd_data[rd_base + j], ref_mem[ad]);
            // Two idle cycles after acceptance, then one word per cycle
            if (mode == 0) check_eq("rd_cycle", rd_cyc[rd_base + j], acc_cyc + 3 + j);
        end
        verify_done((len == 0 || rd_cyc.size() == rd_base) ? acc_cyc : rd_cyc[$]);
`ifdef RAM_BURST_STATS_EN
        check_eq("rd_stall_count", StallCount, stall_obs - stall_base);
`endif
    endtask

    initial begin
        int d;
        Reset = 1'b1;
        CmdValid = 0; CmdWrite = 0; CmdAddr = 0; CmdLen = 0;
        WrData = 0; WrValid = 0; RdReady = 0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_eq("rst_cmd_ready", CmdReady, 1);
        check_eq("rst_wr_ready", WrReady, 0);
        check_eq("rst_rd_valid", RdValid, 0);
        check_eq("rst_done", Done, 0);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_mem_write", MemWrite, 0);
        check_eq("rst_mem_addr", MemAddr, 0);
        check_eq("rst_mem_input", MemInput, 0);
`ifdef RAM_BURST_STATS_EN
        check_eq("rst_stall_count", StallCount, 0);
`endif
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Zero-length commands: no RAM activity, Done next cycle, stays ready
        send_cmd(1'b1, 8'h33, 0);
        check_eq("len0_cmd_ready", CmdReady, 1);
        check_eq("len0_busy", Busy, 0);
        verify_done(acc_cyc);
        check_eq("len0_no_write", wr_cyc.size() - wr_base, 0);
        read_burst(8'h44, 0, 0);
        check_eq("len0_no_rdvalid", rdv_cnt - rdv_base, 0);

        for (int i = 0; i < 4; i++) wdata[i] = 8'hA1 + 8'(i);
        write_burst(8'h10, 4, 1'b0, 1'b1);
        read_burst(8'h10, 4, 0);

        // Fill the whole RAM so any read compares against known contents
        for (int i = 0; i < 100; i++) wdata[i] = 8'(i);
        write_burst(8'h00, 100, 1'b0, 1'b1);
        for (int i = 0; i < 156; i++) wdata[i] = 8'($urandom);
        write_burst(8'd100, 156, 1'b1, 1'b1);

        read_burst(8'h00, 100, 0);
        read_burst(8'h20, 8, 1);

        for (int i = 0; i < 4; i++) wdata[i] = 8'($urandom);
        write_burst(8'hFE, 4, 1'b0, 1'b1);
        read_burst(8'hFE, 4, 2);

        // New command offered in the Done cycle is taken in that cycle
        for (int i = 0; i < 3; i++) wdata[i] = 8'($urandom);
        write_burst(8'h80, 3, 1'b0, 1'b0);
        d = cyc;
        send_cmd(1'b0, 8'h00, 0);
        check_eq("b2b_accept_cycle", acc_cyc, d);
        check_eq("b2b_prev_done_cycle", done_cyc[done_base - 1], d);
        verify_done(acc_cyc);

        for (int n = 0; n < 16; n++) begin
            logic [7:0] ra;
            int rl;
            ra = 8'($urandom);
            rl = $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < rl; i++) wdata[i] = 8'($urandom);
                write_burst(ra, rl, 1'b1, 1'b1);
            end else begin
                read_burst(ra, rl, $urandom_range(0, 2));
            end
        end

        // Reset on the third word of an 8-word write
        for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom);
        send_cmd(1'b1, 8'h40, 8);
        WrValid = 1'b1;
        WrData = wdata[0];
        @(posedge Clk); #1;
        WrData = wdata[1];
        @(posedge Clk); #1;
        WrValid = 1'b0;
        @(posedge Clk); #1;
`ifdef RAM_BURST_STATS_EN
        check_eq("pre_rst_stall_count", StallCount, 1);
`endif
        WrValid = 1'b1;
        WrData = wdata[2];
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("rst_gates_write", MemWrite, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        WrValid = 1'b0;
        check_eq("abort_busy", Busy, 0);
        check_eq("abort_cmd_ready", CmdReady, 1);
        check_eq("abort_wr_ready", WrReady, 0);
        check_eq("abort_mem_addr", MemAddr, 0);
`ifdef RAM_BURST_STATS_EN
        check_eq("abort_stall_count", StallCount, 0);
`endif
        repeat (6) @(posedge Clk);
        #1;
        check_eq("abort_writes", wr_cyc.size() - wr_base, 2);
        check_eq("abort_no_done", done_cyc.size() - done_base, 0);
        ref_mem[8'h40] = wdata[0];
        ref_mem[8'h41] = wdata[1];
        read_burst(8'h40, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
